// File: rtl/score_bcd_display.sv
// score_bcd_display: sequential double-dabble score-to-BCD converter driving a 3-digit multiplexed 7-segment display.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits in score mode.
module score_bcd_display #(
    parameter int REFRESH_CYCLES = 1000,
    parameter int CNT_W          = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  score,
    input  logic        show_score,
    input  logic [6:0]  mole_seg,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [2:0]  digit_en,
    output logic [11:0] bcd,
    output logic        bcd_valid
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state;
    logic           pending;
    logic [7:0]     last;
    logic [19:0]    sr;
    logic [19:0]    adj;
    logic [2:0]     iter;
    logic [CNT_W-1:0] rcnt;
    logic [1:0]     idx;
    logic [3:0]     nib;
    logic           blank;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return n >= 4'd5 ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'h7F;
        endcase
    endfunction

    assign adj = {add3(sr[19:16]), add3(sr[15:12]), add3(sr[11:8]), sr[7:0]};
    assign nib = idx == 2'd2 ? bcd[11:8] : idx == 2'd1 ? bcd[7:4] : bcd[3:0];

`ifdef LEADING_ZERO_BLANK_EN
    assign blank = (idx == 2'd2 && bcd[11:8] == 4'd0) ||
                   (idx == 2'd1 && bcd[11:8] == 4'd0 && bcd[7:4] == 4'd0);
`else
    assign blank = 1'b0;
`endif

    // conversion engine: capture, 8 shift-add-3 steps, then publish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= 1'b1;
            last      <= '0;
            sr        <= '0;
            iter      <= '0;
            bcd       <= '0;
            bcd_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pending || score != last) begin
                    sr        <= {12'd0, score};
                    last      <= score;
                    pending   <= 1'b0;
                    bcd_valid <= 1'b0;
                    iter      <= '0;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    sr    <= {adj[18:0], 1'b0};
                    iter  <= iter + 3'd1;
                    state <= iter == 3'd7 ? DONE : SHIFT;
                end
                DONE: begin
                    bcd       <= sr[19:8];
                    bcd_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt     <= '0;
            idx      <= '0;
            seg      <= 7'h7F;
            dp       <= 1'b1;
            digit_en <= 3'b111;
        end else begin
            rcnt <= rcnt == CNT_W'(REFRESH_CYCLES - 1) ? '0 : rcnt + 1'b1;
            if (rcnt == CNT_W'(REFRESH_CYCLES - 1))
                idx <= idx == 2'd2 ? 2'd0 : idx + 2'd1;
            if (!show_score) begin
                seg      <= mole_seg;
                dp       <= 1'b1;
                digit_en <= 3'b110;
            end else begin
                seg      <= blank ? 7'h7F : decode(nib);
                dp       <= !(idx == 2'd0 && !bcd_valid);
                digit_en <= blank ? 3'b111 : ~(3'b001 << idx);
            end
        end
    end
endmodule

// File: tb/tb_score_bcd_display.sv
// tb_score_bcd_display: directed bench with a BCD scoreboard and an edge-count model of the display scan.
module tb_score_bcd_display;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  score;
    logic        show_score;
    logic [6:0]  mole_seg;
    logic [6:0]  seg;
    logic        dp;
    logic [2:0]  digit_en;
    logic [11:0] bcd;
    logic        bcd_valid;

    int n_assert = 0;
    int n_fail   = 0;
    int edges    = 0;
    int cur      = 0;
    int k;
    logic        pv = 1'b0;
    logic [11:0] sb[$];
    logic [11:0] exp_bcd;

    localparam logic [6:0] SEG_TAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    score_bcd_display #(.REFRESH_CYCLES(4), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .score(score), .show_score(show_score), .mole_seg(mole_seg),
        .seg(seg), .dp(dp), .digit_en(digit_en), .bcd(bcd), .bcd_valid(bcd_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) edges <= 0;
        else edges <= edges + 1;

    function automatic logic [11:0] to_bcd(input int v);
        return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    // expected {digit_en, seg, dp} after edge e in score mode
    function automatic logic [10:0] exp_disp(input int e, input logic [11:0] b, input logic v);
        int i;
        logic [3:0] n;
        logic bl;
        i  = ((e - 1) / 4) % 3;
        n  = b[i*4 +: 4];
        bl = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        bl = (i == 2 && b[11:8] == 0) || (i == 1 && b[11:8] == 0 && b[7:4] == 0);
`endif
        return {bl ? 3'b111 : ~(3'b001 << i), bl ? 7'h7F : SEG_TAB[n], !(i == 0 && !v)};
    endfunction

    task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_seg"}, 20'(seg), 20'h7F);
        chk({tag, "_dp"}, 20'(dp), 20'h1);
        chk({tag, "_en"}, 20'(digit_en), 20'h7);
        chk({tag, "_bcd"}, 20'(bcd), 20'h0);
        chk({tag, "_valid"}, 20'(bcd_valid), 20'h0);
    endtask

    task automatic chk_scan(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk(tag, 20'({digit_en, seg, dp}), 20'(exp_disp(edges, to_bcd(cur), 1'b1)));
        end
    endtask

    task automatic drive(input int v);
        score = 8'(v);
        cur   = v;
        sb.push_back(to_bcd(v));
    endtask

    // call right after driving a new score; checks capture-to-valid latency
    task automatic wait_valid(input string tag);
        int c;
        tick();
        c = 0;
        while (bcd_valid !== 1'b1 && c < 30) begin
            tick();
            c++;
        end
        chk({tag, "_latency"}, 20'(c), 20'd9);
    endtask

    // scoreboard: pop expected BCD on each rising bcd_valid
    always @(posedge clk) begin
        #1;
        if (rst_n && bcd_valid && !pv) begin
            if (sb.size() == 0) begin
                n_assert++;
                n_fail++;
                $error("FAIL sb_empty observed=%h expected=none", bcd);
            end else begin
                exp_bcd = sb.pop_front();
                chk("sb_bcd", 20'(bcd), 20'(exp_bcd));
            end
        end
        pv = bcd_valid;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1; score = 8'd0; show_score = 1'b1; mole_seg = 7'h7F;
        #1 rst_n = 1'b0;
        drive(0);
        #20;
        chk_reset("reset");
        rst_n = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            tick();
            chk("rst_busy", 20'(bcd_valid), 20'h0);
            chk("rst_busy_disp", 20'({digit_en, seg, dp}), 20'(exp_disp(edges, 12'h000, 1'b0)));
        end
        tick();
        chk("rst_valid", 20'(bcd_valid), 20'h1);
        chk("rst_bcd", 20'(bcd), 20'h000);
        chk_scan("scan_zero", 12);

        drive(255);
        wait_valid("s255");
        chk("bcd255", 20'(bcd), 20'h255);
        chk_scan("scan_255", 12);

        drive(100);
        tick();
        tick();
        tick();
        drive(42);
        repeat (7) tick();
        chk("c9_valid", 20'(bcd_valid), 20'h1);
        chk("c9_bcd", 20'(bcd), 20'h100);
        tick();
        chk("c10_valid", 20'(bcd_valid), 20'h0);
        chk("c10_bcd", 20'(bcd), 20'h100);
        repeat (9) tick();
        chk("c19_valid", 20'(bcd_valid), 20'h1);
        chk("c19_bcd", 20'(bcd), 20'h042);

        show_score = 1'b0;
        mole_seg   = 7'b1111011;
        tick();
        chk("play", 20'({digit_en, seg, dp}), 20'({3'b110, 7'b1111011, 1'b1}));
        tick();
        chk("play_hold", 20'({digit_en, seg, dp}), 20'({3'b110, 7'b1111011, 1'b1}));
        show_score = 1'b1;
        tick();
        chk("back_score", 20'({digit_en, seg, dp}), 20'(exp_disp(edges, 12'h042, 1'b1)));

        drive(7);
        wait_valid("s7");
        chk_scan("scan_7", 12);
        drive(10);
        wait_valid("s10");
        chk_scan("scan_10", 12);

        drive(200);
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk_reset("async_rst");
        rst_n = 1'b1;
        sb.push_back(to_bcd(200));
        k = 0;
        while (bcd_valid !== 1'b1 && k < 30) begin
            tick();
            k++;
        end
        chk("post_rst_latency", 20'(k), 20'd10);
        chk("post_rst_bcd", 20'(bcd), 20'h200);
        chk_scan("scan_200", 12);
        tick();
        chk("sb_drained", 20'(sb.size()), 20'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/score_bcd_display.md
Name: score_bcd_display

Overview:
Downstream consumer of the game FSM's 8-bit binary score and the game-end flag. Converts the score to 3-digit BCD with a sequential shift-add-3 (double-dabble) engine. Drives a time-multiplexed 3-digit common-anode 7-segment display. During play it passes the mole segment pattern through to the ones digit; after game end it shows the decimal score 000–255.

Parameters:
REFRESH_CYCLES, 1000, clk cycles each digit stays enabled before the scan advances (min 2).
CNT_W, 10, width of the refresh counter; must satisfy 2^CNT_W >= REFRESH_CYCLES.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
score  in  8  binary score from game FSM
show_score  in  1  1 = game over, display decimal score; 0 = play mode
mole_seg  in  7  active-low gfedcba mole pattern, used in play mode
seg  out  7  active-low gfedcba segment drive, registered
dp  out  1  active-low decimal point, registered
digit_en  out  3  active-low anodes: [0] ones, [1] tens, [2] hundreds, registered
bcd  out  12  {hundreds, tens, ones} BCD of last completed conversion
bcd_valid  out  1  1 = bcd matches the last captured score

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
- Reset values: seg=7'h7F, dp=1, digit_en=3'b111, bcd=0, bcd_valid=0, FSM=IDLE, refresh count=0, digit index=0, pending=1.
- Conversion FSM has three states: IDLE, SHIFT, DONE.
- IDLE: if pending, or score differs from the last captured value, then at capture edge C:
  - latch score into the shift register and the last-captured register;
  - clear pending;
  - bcd_valid<=0;
  - go to SHIFT.
- SHIFT: runs exactly 8 cycles (edges C+1..C+8). Each cycle, add 3 to every BCD nibble >=5, then shift left one bit. The iteration counter is 3 bits.
- DONE: at edge C+9, write bcd, set bcd_valid<=1, return to IDLE. Capture-to-valid latency is 9 cycles; after reset the first capture is at the first clock edge.
- While converting, bcd keeps its old value. A score change during SHIFT/DONE does not abort the conversion; it is detected in IDLE and triggers a new conversion at edge C+10.
- Scan: the refresh counter counts 0..REFRESH_CYCLES-1 and then wraps.
  - On wrap, the digit index advances 0→1→2→0.
  - The scan runs continuously in both modes.
- Play mode (show_score=0): seg<=mole_seg, dp<=1, digit_en<=3'b110 (ones digit only, no scanning visible).
- Score mode (show_score=1):
  - digit_en<=~(1<<index);
  - seg<=decode(bcd nibble[index]) using the standard active-low table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000;
  - nibble >9 decodes to 7'h7F;
  - dp<=0 on the ones digit when bcd_valid=0 (busy indicator), otherwise dp<=1.
- All display outputs are registered: one cycle of latency from show_score, mole_seg, bcd and index.
- Switching show_score mid-scan takes effect on the next edge; the scan position is not reset.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: in score mode, the hundreds digit is blanked (seg=7'h7F and its digit_en bit =1) when hundreds==0; the tens digit is blanked when hundreds==0 and tens==0. The ones digit is never blanked, so 0 shows as "0". The scan timing is unchanged.
- Undefined: all three digits are always shown, including leading zeros ("007").

Test Plan:
1. Reset with score=0, show_score=1 → bcd_valid=0 through edge 9, =1 at edge 10 after rst_n rises; bcd=12'h000. With REFRESH_CYCLES=4, digit_en repeats 110,101,011, each held 4 cycles; seg=1000000 on every digit (macro undefined).
2. score=255 → 9 cycles after capture, bcd=12'h255, bcd_valid=1. Hundreds digit seg=0100100, tens=0010010, ones=0010010.
3. score=100, then score=42 two cycles after capture → bcd=12'h100 valid at C+9, bcd_valid drops at C+10, bcd=12'h042 at C+19.
4. show_score=0, mole_seg=7'b1111011 → next edge: seg=1111011, digit_en=110, dp=1. Then show_score=1 → score-mode decode from the next edge.
5. LEADING_ZERO_BLANK_EN defined, score=7 → hundreds and tens slots show digit_en all-high and seg=7F; ones shows 1111000. With score=10, tens shows 1111001.
6. Assert rst_n low mid-SHIFT → all outputs return to reset values immediately (asynchronously). After release, a fresh conversion completes with a correct bcd.
